if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the PC4/Inst pair consumed by the IF/ID pipeline register.
- Owns the architectural fetch PC and runs a single-outstanding request/ready handshake to instruction memory.
- Holds one fetched instruction until the ID side accepts it (HzCtrl 00), drops it on flush or redirect, and otherwise presents a NOP bubble.
- Sits between imem and IF_ID; HzCtrl comes from the hazard unit, Redirect/RedirectPC from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction presented when no valid instruction is held (sll $0,$0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- HzCtrl  in  2  00 normal/consume, 01 flush, 10 stall; 11 is treated as stall.
- Redirect  in  1  one-cycle pulse: change fetch PC.
- RedirectPC  in  32  new fetch target; bits [1:0] ignored and forced to 00.
- IMemReq  out  1  fetch request; held until IMemRdy.
- IMemAddr  out  32  word-aligned fetch address; stable while IMemReq=1.
- IMemRdy  in  1  memory ack; IMemData is valid in the same cycle.
- IMemData  in  32  fetched instruction.
- FetchValid  out  1  Inst/PC4 hold a real instruction.
- Inst  out  32  instruction to IF_ID; NOP_INST when FetchValid=0.
- PC4  out  32  address of Inst + 4; 0 when FetchValid=0.

Behaviour:
- Registers:
  - ReqAddr: address of the in-flight request.
  - NextPC: next sequential fetch address.
  - BufInst, BufPC: held instruction and its address.
  - state ∈ {FETCH, DRAIN, HOLD}.
- Reset (sync, on rst=1 at posedge):
  - state=FETCH, ReqAddr=RESET_PC, NextPC=RESET_PC+4, buffer invalid.
  - Outputs after the edge: IMemReq=1, IMemAddr=RESET_PC, FetchValid=0, Inst=NOP_INST, PC4=0.
  - imem shares rst, so an aborted in-flight request needs no draining.
- Outputs are decoded from registers only; there is no combinational path from IMemData to Inst.
  - IMemReq=1 in FETCH and DRAIN.
  - IMemAddr=ReqAddr.
  - FetchValid=1 only in HOLD; then Inst=BufInst and PC4=BufPC+4.
- FETCH:
  - IMemRdy=1, no Redirect: BufInst←IMemData, BufPC←ReqAddr, NextPC←ReqAddr+4 → HOLD.
  - IMemRdy=1, Redirect: data discarded; ReqAddr←RedirectPC, NextPC←RedirectPC+4; stay FETCH.
  - IMemRdy=0, Redirect: NextPC←RedirectPC → DRAIN. ReqAddr is unchanged because the request cannot be withdrawn.
  - IMemRdy=0, no Redirect: wait.
  - HzCtrl is ignored here; nothing is buffered, so IF_ID latches a bubble if it samples.
- DRAIN (request in flight but stale):
  - Another Redirect updates NextPC; the latest redirect wins.
  - On IMemRdy: data discarded; ReqAddr←NextPC; NextPC←NextPC+4 → FETCH.
- HOLD:
  - Redirect has highest priority: buffer dropped; ReqAddr←RedirectPC, NextPC←RedirectPC+4 → FETCH.
  - Else HzCtrl=00: instruction consumed by IF_ID at this edge; ReqAddr←NextPC, NextPC←NextPC+4 → FETCH.
  - Else HzCtrl=01: buffer dropped; refetch from NextPC the same way → FETCH.
  - Else (10/11): hold all state; outputs stable.
- Latency and throughput:
  - Inst becomes visible the cycle after the IMemRdy cycle.
  - Zero-wait memory gives one instruction every 2 cycles. This is accepted; prefetch is out of scope.
- Arithmetic: all +4 operations are 32-bit modulo, so 32'hFFFF_FFFC+4 = 0. NextPC/ReqAddr bits [1:0] are always 00.
- Simultaneous events: Redirect overrides HzCtrl in every state. rst overrides everything.

Decomposition:
- Shared package holds:
  - HzCtrl encodings HZ_NORMAL=2'b00, HZ_FLUSH=2'b01, HZ_STALL=2'b10 (also used by IF_ID and the hazard unit).
  - NOP_INST and RESET_PC constants.
  - The fetch state enum.
- One flat module; no sub-module is warranted.

Test Plan:
- Reset, then IMemRdy=1 every cycle while requested, HzCtrl=00, memory returns addr^32'hA5A5_0000:
  - IMemAddr sequence 0x0040_0000, 0x0040_0004, ….
  - Inst valid every other cycle, with PC4=0x0040_0004, 0x0040_0008.
- HOLD with Inst from 0x0040_0008, HzCtrl=10 for 3 cycles then 00:
  - Inst/PC4 stable (PC4=0x0040_000C) throughout the stall.
  - Next IMemAddr=0x0040_000C.
- FETCH at 0x0040_0010 with IMemRdy low; Redirect=1, RedirectPC=0x0040_0103; IMemRdy after 2 cycles:
  - IMemAddr stays 0x0040_0010 until ack; returned data is never shown.
  - Next IMemAddr=0x0040_0100.
- HOLD with Redirect=1 (0x0040_0200) and HzCtrl=01 in the same cycle:
  - FetchValid=0 next cycle; IMemAddr=0x0040_0200.
  - The subsequent Inst has PC4=0x0040_0204.
- Redirect to 0xFFFF_FFFC, consume:
  - PC4=0x0000_0000 shown; next IMemAddr=0x0000_0000 (wrap).
- rst asserted in DRAIN:
  - Next cycle state FETCH, IMemAddr=RESET_PC, FetchValid=0, Inst=0, PC4=0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and its pipeline neighbours.
// The hazard-control encodings are also decoded by IF_ID and the hazard unit.
package if_fetch_unit_pkg;

   localparam logic [1:0] HZ_NORMAL = 2'b00;
   localparam logic [1:0] HZ_FLUSH  = 2'b01;
   localparam logic [1:0] HZ_STALL  = 2'b10;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      StFetch,
      StDrain,
      StHold
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding imem handshake
// and holds one instruction for IF_ID until it is consumed, flushed or redirected.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  HzCtrl,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemRdy,
   input  logic [31:0] IMemData,
   output logic        FetchValid,
   output logic [31:0] Inst,
   output logic [31:0] PC4
);

   import if_fetch_unit_pkg::*;

   fetch_state_e state_q, state_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  next_pc_q, next_pc_d;
   logic [31:0]  buf_inst_q, buf_inst_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  redir_pc;

   assign redir_pc = RedirectPC & 32'hFFFF_FFFC;

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      next_pc_d  = next_pc_q;
      buf_inst_d = buf_inst_q;
      buf_pc_d   = buf_pc_q;

      unique case (state_q)
         StFetch: begin
            if (IMemRdy) begin
               if (Redirect) begin
                  req_addr_d = redir_pc;
                  next_pc_d  = redir_pc + 32'd4;
               end else begin
                  buf_inst_d = IMemData;
                  buf_pc_d   = req_addr_q;
                  next_pc_d  = req_addr_q + 32'd4;
                  state_d    = StHold;
               end
            end else if (Redirect) begin
               // The request cannot be withdrawn; remember the target and drain it.
               next_pc_d = redir_pc;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            if (Redirect && IMemRdy) begin
               req_addr_d = redir_pc;
               next_pc_d  = redir_pc + 32'd4;
               state_d    = StFetch;
            end else if (Redirect) begin
               next_pc_d = redir_pc;
            end else if (IMemRdy) begin
               req_addr_d = next_pc_q;
               next_pc_d  = next_pc_q + 32'd4;
               state_d    = StFetch;
            end
         end
         StHold: begin
            if (Redirect) begin
               req_addr_d = redir_pc;
               next_pc_d  = redir_pc + 32'd4;
               state_d    = StFetch;
            end else begin
               unique case (HzCtrl)
                  HZ_NORMAL, HZ_FLUSH: begin
                     req_addr_d = next_pc_q;
                     next_pc_d  = next_pc_q + 32'd4;
                     state_d    = StFetch;
                  end
                  HZ_STALL, 2'b11: ;
                  default: ;
               endcase
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StFetch;
         req_addr_q <= RESET_PC;
         next_pc_q  <= RESET_PC + 32'd4;
         buf_inst_q <= NOP_INST;
         buf_pc_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         next_pc_q  <= next_pc_d;
         buf_inst_q <= buf_inst_d;
         buf_pc_q   <= buf_pc_d;
      end
   end

   assign IMemReq    = (state_q != StHold);
   assign IMemAddr   = req_addr_q;
   assign FetchValid = (state_q == StHold);
   assign Inst       = FetchValid ? buf_inst_q : NOP_INST;
   assign PC4        = FetchValid ? (buf_pc_q + 32'd4) : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the fetch stream.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  HzCtrl;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemRdy;
   logic [31:0] IMemData;
   logic        FetchValid;
   logic [31:0] Inst;
   logic [31:0] PC4;

   int tests = 0;
   int fails = 0;

   // Model: address in flight, whether its data is wanted, where fetching continues,
   // and the instruction (if any) waiting for the decode side.
   logic [31:0] m_inflight;
   logic        m_stale;
   logic [31:0] m_target;
   logic        m_held;
   logic [31:0] m_hinst;
   logic [31:0] m_hpc;

   if_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .HzCtrl     (HzCtrl),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemRdy    (IMemRdy),
      .IMemData   (IMemData),
      .FetchValid (FetchValid),
      .Inst       (Inst),
      .PC4        (PC4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".req"},   {31'd0, IMemReq},    {31'd0, !m_held});
      chk({tag, ".addr"},  IMemAddr,            m_inflight);
      chk({tag, ".valid"}, {31'd0, FetchValid}, {31'd0, m_held});
      chk({tag, ".inst"},  Inst,                m_held ? m_hinst : 32'h0);
      chk({tag, ".pc4"},   PC4,                 m_held ? m_hpc + 32'd4 : 32'h0);
   endtask

   // One clock: apply inputs, advance model with the same inputs, check #1 after the edge.
   task automatic step(input logic r, input logic [1:0] hz, input logic rd,
                       input logic [31:0] rpc, input logic rdy, input string tag);
      logic [31:0] tgt;
      rst        = r;
      HzCtrl     = hz;
      Redirect   = rd;
      RedirectPC = rpc;
      IMemRdy    = rdy;
      IMemData   = m_inflight ^ 32'hA5A5_0000;
      tgt        = {rpc[31:2], 2'b00};
      @(posedge clk);
      if (r) begin
         m_inflight = 32'h0040_0000;
         m_target   = 32'h0040_0004;
         m_stale    = 1'b0;
         m_held     = 1'b0;
         m_hinst    = 32'h0;
         m_hpc      = 32'h0;
      end else if (!m_held) begin
         if (rdy) begin
            if (rd) begin
               m_inflight = tgt;
               m_target   = tgt + 32'd4;
               m_stale    = 1'b0;
            end else if (m_stale) begin
               m_inflight = m_target;
               m_target   = m_target + 32'd4;
               m_stale    = 1'b0;
            end else begin
               m_held   = 1'b1;
               m_hinst  = m_inflight ^ 32'hA5A5_0000;
               m_hpc    = m_inflight;
               m_target = m_inflight + 32'd4;
            end
         end else if (rd) begin
            m_stale  = 1'b1;
            m_target = tgt;
         end
      end else begin
         if (rd) begin
            m_held     = 1'b0;
            m_inflight = tgt;
            m_target   = tgt + 32'd4;
         end else if (hz == 2'b00 || hz == 2'b01) begin
            m_held     = 1'b0;
            m_inflight = m_target;
            m_target   = m_target + 32'd4;
         end
      end
      #1;
      check_model(tag);
   endtask

   initial begin
      logic [31:0] stall_pc4;
      logic [31:0] stall_inst;
      m_inflight = 32'h0;
      m_target   = 32'h0;
      m_stale    = 1'b0;
      m_held     = 1'b0;
      m_hinst    = 32'h0;
      m_hpc      = 32'h0;

      // Reset
      step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, "reset");
      chk("reset_addr", IMemAddr, 32'h0040_0000);
      chk("reset_inst", Inst, 32'h0);
      chk("reset_pc4", PC4, 32'h0);

      // Zero-wait memory, normal consumption
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "zw0");
      chk("zw0_pc4", PC4, 32'h0040_0004);
      chk("zw0_inst", Inst, 32'h0040_0000 ^ 32'hA5A5_0000);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "zw1");
      chk("zw1_addr", IMemAddr, 32'h0040_0004);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "zw2");
      chk("zw2_pc4", PC4, 32'h0040_0008);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "zw3");
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "zw4");
      chk("zw4_pc4", PC4, 32'h0040_000C);

      // Stall: 10, 10, 11, then consume
      stall_pc4  = PC4;
      stall_inst = Inst;
      step(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "st0");
      step(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, "st1");
      step(1'b0, 2'b11, 1'b0, 32'h0, 1'b0, "st2");
      chk("stall_pc4", PC4, stall_pc4);
      chk("stall_inst", Inst, stall_inst);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "st3");
      chk("after_stall_addr", IMemAddr, 32'h0040_000C);

      // Redirect while request in flight
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "d0");
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "d1");
      chk("drain_req_addr", IMemAddr, 32'h0040_0010);
      step(1'b0, 2'b00, 1'b1, 32'h0040_0103, 1'b0, "d2");
      chk("drain_hold_addr", IMemAddr, 32'h0040_0010);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "d3");
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "d4");
      chk("drain_valid", {31'd0, FetchValid}, 32'd0);
      chk("drain_next_addr", IMemAddr, 32'h0040_0100);

      // Redirect and flush together in HOLD
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "rf0");
      step(1'b0, 2'b01, 1'b1, 32'h0040_0200, 1'b0, "rf1");
      chk("rf_valid", {31'd0, FetchValid}, 32'd0);
      chk("rf_addr", IMemAddr, 32'h0040_0200);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "rf2");
      chk("rf_pc4", PC4, 32'h0040_0204);

      // Wrap at top of address space
      step(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFC, 1'b0, "w0");
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "w1");
      chk("wrap_pc4", PC4, 32'h0);
      chk("wrap_valid", {31'd0, FetchValid}, 32'd1);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, "w2");
      chk("wrap_addr", IMemAddr, 32'h0);

      // Reset while draining
      step(1'b0, 2'b00, 1'b1, 32'h0000_1000, 1'b0, "rd0");
      step(1'b1, 2'b00, 1'b0, 32'h0, 1'b0, "rd1");
      chk("rst_drain_addr", IMemAddr, 32'h0040_0000);
      chk("rst_drain_req", {31'd0, IMemReq}, 32'd1);
      step(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, "rd2");
      chk("rst_drain_pc4", PC4, 32'h0040_0004);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic        r;
         logic [1:0]  hz;
         logic        rd;
         logic [31:0] rpc;
         logic        rdy;
         r   = ($urandom_range(0, 79) == 0);
         hz  = 2'($urandom_range(0, 3));
         rd  = ($urandom_range(0, 7) == 0);
         rpc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                           : $urandom;
         rdy = !m_held && ($urandom_range(0, 1) == 1);
         step(r, hz, rd, rpc, rdy, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
